// File: rtl/arb_fmt_ctrl.sv
// ============================================================================
// arb_fmt_ctrl
// ----------------------------------------------------------------------------
// Three-channel read arbiter and packet formatter.
//
// Each slave channel owns a FIFO. The FIFO reports three things:
//    - "not empty" on slv_req_i.
//    - Its free slot count on slv_margin_i.
//    - Read data on slv_val_i/slv_data_i, one cycle after this block pops it
//      with a2s_ack_o.
//
// While idle, the block picks one channel that is enabled, non-empty and holds
// at least one full packet. The lowest priority value wins. Ties rotate
// round-robin, starting after the last granted channel. The block then pops
// exactly LEN words from the winner and streams them out on the fmt_* port.
// The first word is marked with fmt_start_o and the last with fmt_end_o.
//
// A two-entry output buffer absorbs the one-cycle read latency of the slaves.
// Pops are throttled so that buffered words plus pops still in flight never
// exceed two. With fmt_ready_i held high this still gives one word per cycle.
//
// Parameters
//    DW          channel / output data width
//    FIFO_DEPTH  depth of each slave FIFO, used to turn margin into fill level
//
// Ports
//    clk_i         clock, rising edge
//    rstn_i        asynchronous active-low reset
//    slv_en_i      per-channel enable
//    slv_req_i     per-channel FIFO-not-empty
//    slv_margin_i  per-channel free slots, 8 bits each, channel x at [8x+7:8x]
//    slv_val_i     per-channel read data valid (one cycle after ack)
//    slv_data_i    per-channel read data, channel x at [DW*x+DW-1:DW*x]
//    a2s_ack_o     per-channel read pop, at most one bit high
//    prio_i        2-bit priority per channel, 0 is highest
//    pkt_len_i     packet length code: 0=4, 1=8, 2=16, 3=32 words
//    fmt_data_o    formatted output word
//    fmt_val_o     output word valid
//    fmt_ready_i   downstream accept
//    fmt_start_o   first word of a packet
//    fmt_end_o     last word of a packet
//    fmt_id_o      source channel of the current word
//    busy_o        high whenever the controller is not idle
// ============================================================================
module arb_fmt_ctrl #(
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 64
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic [2:0]      slv_en_i,
   input  logic [2:0]      slv_req_i,
   input  logic [23:0]     slv_margin_i,
   input  logic [2:0]      slv_val_i,
   input  logic [3*DW-1:0] slv_data_i,
   output logic [2:0]      a2s_ack_o,
   input  logic [5:0]      prio_i,
   input  logic [1:0]      pkt_len_i,
   output logic [DW-1:0]   fmt_data_o,
   output logic            fmt_val_o,
   input  logic            fmt_ready_i,
   output logic            fmt_start_o,
   output logic            fmt_end_o,
   output logic [1:0]      fmt_id_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] DEPTH_8 = 8'(FIFO_DEPTH);

   state_t        state_q;
   state_t        state_d;

   logic [5:0]    req_len;
   logic [7:0]    fill [3];
   logic [2:0]    eligible;
   logic          win_valid;
   logic [1:0]    win_ch;

   logic [5:0]    len_q;
   logic [1:0]    grant_q;
   logic [1:0]    last_q;
   logic [5:0]    ack_cnt_q;
   logic [5:0]    out_cnt_q;

   logic [DW-1:0] buf_q [2];
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    bcnt_q;
   logic          inflight_q;

   logic          pop;
   logic          push;
   logic [2:0]    cnt;
   logic          ack_fire;
   logic          ack_last;
   logic          word_last;

   // Translate the packet length code into a word count.
   // The result is 4, 8, 16 or 32 and fits in six bits.
   always_comb begin
      req_len = 6'd4 << pkt_len_i;
   end

   // A channel may compete only when it is enabled and not empty.
   // It must also already hold a whole packet. Fill is computed modulo 256,
   // so a margin larger than the FIFO depth wraps to a large fill value.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         fill[i]     = DEPTH_8 - slv_margin_i[8*i +: 8];
         eligible[i] = slv_en_i[i] && slv_req_i[i] &&
                       (fill[i] >= {2'b00, req_len});
      end
   end

   // Visit the channels in round-robin order, starting after last_q.
   // A candidate replaces the current best only with a strictly lower
   // priority value. Equal priorities therefore resolve to the channel
   // reached first in the rotation.
   always_comb begin
      logic [2:0] cand;
      logic [1:0] cand_prio;
      logic [1:0] best_prio;
      win_valid = 1'b0;
      win_ch    = 2'd0;
      best_prio = 2'd3;
      cand      = 3'd0;
      cand_prio = 2'd0;
      for (int k = 0; k < 3; k++) begin
         cand = {1'b0, last_q} + 3'(k) + 3'd1;
         if (cand >= 3'd3) begin
            cand = cand - 3'd3;
         end
         cand_prio = prio_i[2*cand[1:0] +: 2];
         if (eligible[cand[1:0]] && (!win_valid || (cand_prio < best_prio))) begin
            win_valid = 1'b1;
            win_ch    = cand[1:0];
            best_prio = cand_prio;
         end
      end
   end

   // Output-side handshake and buffer occupancy.
   // cnt counts every word this block is already responsible for: words
   // waiting in the buffer plus a pop whose data has not returned yet.
   // A new pop is allowed only if the word leaving this cycle still leaves
   // room for it.
   assign fmt_val_o = (bcnt_q != 2'd0);
   assign pop       = fmt_val_o && fmt_ready_i;
   assign push      = (state_q != IDLE) && slv_val_i[grant_q];
   assign cnt       = {1'b0, bcnt_q} + {2'b00, inflight_q};
   assign ack_fire  = (state_q == XFER) && ((cnt - {2'b00, pop}) < 3'd2);
   assign ack_last  = (ack_cnt_q == (len_q - 6'd1));
   assign word_last = (out_cnt_q == (len_q - 6'd1));

   // Controller state register.
   // Reset drops straight back to IDLE, so a partial packet is abandoned.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and pop generation.
   // XFER issues exactly LEN pops and moves to DRAIN together with the last
   // one. DRAIN waits for the final word to leave before returning to IDLE.
   // IDLE always lasts at least one cycle between packets, because a new
   // arbitration only happens in IDLE.
   always_comb begin
      state_d   = state_q;
      a2s_ack_o = 3'b000;
      unique case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (ack_fire) begin
               a2s_ack_o = 3'b001 << grant_q;
               if (ack_last) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && word_last) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Per-packet context, counters and the two-entry return buffer.
   // Length and winner are frozen when the packet starts, so later changes
   // on pkt_len_i, prio_i or slv_en_i cannot disturb a packet in progress.
   // The priority only matters at the arbitration instant, and its outcome
   // is what grant_q holds. Read data is taken only from the granted
   // channel. Reset clears the buffer contents too, so fmt_data_o reads
   // zero while in reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         len_q      <= 6'd0;
         grant_q    <= 2'd0;
         last_q     <= 2'd2;
         ack_cnt_q  <= 6'd0;
         out_cnt_q  <= 6'd0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         bcnt_q     <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && win_valid) begin
            len_q     <= req_len;
            grant_q   <= win_ch;
            last_q    <= win_ch;
            ack_cnt_q <= 6'd0;
            out_cnt_q <= 6'd0;
         end
         if (ack_fire) begin
            ack_cnt_q <= ack_cnt_q + 6'd1;
         end
         inflight_q <= ack_fire;
         if (pop) begin
            out_cnt_q <= word_last ? 6'd0 : (out_cnt_q + 6'd1);
            rd_ptr_q  <= ~rd_ptr_q;
         end
         if (push) begin
            buf_q[wr_ptr_q] <= slv_data_i[DW*grant_q +: DW];
            wr_ptr_q        <= ~wr_ptr_q;
         end
         case ({push, pop})
            2'b10:   bcnt_q <= bcnt_q + 2'd1;
            2'b01:   bcnt_q <= bcnt_q - 2'd1;
            default: bcnt_q <= bcnt_q;
         endcase
      end
   end

   // Word markers come from the count of words already accepted
   // downstream. That count only moves on a transfer, so the markers, the
   // data and the id all hold still while the receiver stalls.
   assign fmt_data_o  = buf_q[rd_ptr_q];
   assign fmt_id_o    = grant_q;
   assign fmt_start_o = fmt_val_o && (out_cnt_q == 6'd0);
   assign fmt_end_o   = fmt_val_o && word_last;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/arb_fmt_ctrl.md
ARB_FMT_CTRL -- requirements
Module: arb_fmt_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 32, channel data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 64, per-channel slave FIFO depth used to derive fill level.
REQ-003 The block SHALL have port clk_i, input, 1, clock; all logic on rising edge.
REQ-004 The block SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port slv_en_i, input, 3, per-channel enable; bit x = channel x.
REQ-006 The block SHALL have port slv_req_i, input, 3, per-channel FIFO-not-empty.
REQ-007 The block SHALL have port slv_margin_i, input, 24, per-channel FIFO free slots, 8 bits per channel, channel x at [8x+7:8x].
REQ-008 The block SHALL have port slv_val_i, input, 3, per-channel read-data valid, one cycle after ack.
REQ-009 The block SHALL have port slv_data_i, input, 3*DW, per-channel read data, channel x at [DW*x+DW-1:DW*x].
REQ-010 The block SHALL have port a2s_ack_o, output, 3, per-channel read pop; at most one bit high.
REQ-011 The block SHALL have port prio_i, input, 6, 2-bit priority per channel, channel x at [2x+1:2x]; 0 is highest.
REQ-012 The block SHALL have port pkt_len_i, input, 2, packet length code: 0=4, 1=8, 2=16, 3=32 words.
REQ-013 The block SHALL have port fmt_data_o, output, DW, formatted output word.
REQ-014 The block SHALL have port fmt_val_o, output, 1, output word valid.
REQ-015 The block SHALL have port fmt_ready_i, input, 1, downstream accept; a word transfers when fmt_val_o && fmt_ready_i.
REQ-016 The block SHALL have port fmt_start_o, output, 1, high with the first word of a packet.
REQ-017 The block SHALL have port fmt_end_o, output, 1, high with the last word of a packet.
REQ-018 The block SHALL have port fmt_id_o, output, 2, source channel of the current word.
REQ-019 The block SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.

Function
REQ-020 Fill level of channel x SHALL be FIFO_DEPTH - margin_x, computed at 8 bits; channel x is eligible when slv_en_i[x] && slv_req_i[x] && fill >= LEN.
REQ-021 The FSM SHALL have states IDLE, XFER, DRAIN; IDLE->XFER when any channel is eligible, XFER->DRAIN after LEN acks, DRAIN->IDLE when the last word has transferred.
REQ-022 Winner selection in IDLE: lowest prio value wins; ties broken round-robin starting from the channel after the last granted one; after reset, last granted = channel 2, so ties go 0,1,2.
REQ-023 LEN, grant channel and priority SHALL be latched on IDLE->XFER; changes to pkt_len_i, prio_i, slv_en_i mid-packet SHALL NOT affect the current packet.
REQ-024 An internal 2-entry output buffer SHALL hold returning words; CNT = buffered words + acks in flight.
REQ-025 In XFER, a2s_ack_o[grant] SHALL assert in a cycle only if CNT - pop < 2, where pop = fmt_val_o && fmt_ready_i.
REQ-026 With fmt_ready_i held high, sustained throughput SHALL be one word per cycle.
REQ-027 Slave data SHALL be captured into the buffer when slv_val_i[grant] is high; slv_val_i of non-granted channels SHALL be ignored.
REQ-028 fmt_data_o, fmt_id_o, fmt_start_o, fmt_end_o SHALL be held stable while fmt_val_o && !fmt_ready_i.
REQ-029 fmt_start_o SHALL mark word 0 and fmt_end_o word LEN-1 of each packet; with LEN never 1, both are never high together.
REQ-030 The next arbitration SHALL NOT begin before DRAIN->IDLE; minimum gap between packets SHALL be one IDLE cycle.
REQ-031 A disabled channel SHALL never be granted; disabling the granted channel mid-packet SHALL NOT abort the packet.

Reset
REQ-032 Asserting rstn_i, including mid-packet, SHALL immediately clear a2s_ack_o, fmt_val_o, fmt_start_o, fmt_end_o, busy_o to 0, fmt_data_o to 0, fmt_id_o to 0.
REQ-033 Asserting rstn_i SHALL also clear the buffer, CNT and in-flight tracking, set FSM to IDLE and set last granted to 2; partial packets SHALL be discarded.

Verification
REQ-034 Ch0 only, fill 64 (margin 0), pkt_len_i=0, ready=1 -> 4 acks in consecutive cycles; 4 words out back-to-back with id=0; start on word 0, end on word 3.
REQ-035 Ch1 prio 0, ch2 prio 1, both eligible -> ch1 packet first, then ch2.
REQ-036 All prio 0, all eligible, three packets -> grant order 0,1,2, then 0 again.
REQ-037 Fill 7, pkt_len_i=1 (8) -> no grant and busy_o=0; fill reaches 8 -> grant.
REQ-038 fmt_ready_i low for 5 cycles mid-packet -> at most 2 outstanding acks; outputs stable; no word lost or duplicated.
REQ-039 rstn_i low during word 2 of a 16-word packet -> all outputs 0 asynchronously; after release, FSM in IDLE and the next tie goes to channel 0.
